// File: rtl/csr_exec_unit.sv
// CSR execute unit: decodes Zicsr read/modify/write ops, returns the old CSR
// value to the GPR file one cycle after acceptance and issues a single-cycle
// registered write to the CSR file. Holds one result behind a valid/ready pair.
module csr_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CHECK_PRIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [11:0]       csr_addr,
  input  logic [4:0]        rs1_idx,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [4:0]        rd,
  input  logic [1:0]        priv,
  output logic [11:0]       csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_we,
  output logic [11:0]       csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        rd_out,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_data,
  output logic              exc_illegal
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned REG_W  = 5;
  localparam logic        PRIV_EN = (CHECK_PRIV != 0);

  // funct3[1:0] selects the operation; funct3[2] selects the immediate form
  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  logic            accept;
  logic [XLEN-1:0] operand;
  logic            fwd_hit;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            wr_intent;
  logic            op_ok;
  logic            priv_fail;
  logic            ro_fail;
  logic            illegal;
  logic            do_write;

  // Handshake: a held result blocks new ops unless it drains this cycle
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign csr_raddr = csr_addr;

  // Operand select, forwarding of the in-flight write, and op decode
  always_comb begin
    operand   = rs1_data;
    fwd_hit   = 1'b0;
    old_val   = csr_rdata;
    new_val   = '0;
    wr_intent = 1'b0;
    op_ok     = 1'b1;
    priv_fail = 1'b0;
    ro_fail   = 1'b0;
    illegal   = 1'b0;
    do_write  = 1'b0;

    if (op[2]) begin
      operand = XLEN'(rs1_idx);
    end

    // The CSR file has not yet absorbed last cycle's write, so bypass it
    fwd_hit = csr_we && (csr_waddr == csr_addr);
    if (fwd_hit) begin
      old_val = csr_wdata;
    end

    unique case (op[1:0])
      OP_RW: begin
        new_val   = operand;
        wr_intent = 1'b1;
      end
      OP_RS: begin
        new_val   = old_val | operand;
        wr_intent = (rs1_idx != REG_W'(0));
      end
      OP_RC: begin
        new_val   = old_val & ~operand;
        wr_intent = (rs1_idx != REG_W'(0));
      end
      OP_ILL: begin
        op_ok = 1'b0;
      end
      default: begin
        op_ok = 1'b0;
      end
    endcase

    // Address bits [11:10]==11 mark read-only CSRs; [9:8] give the minimum privilege
    ro_fail   = wr_intent && (csr_addr[11:10] == 2'b11);
    priv_fail = PRIV_EN && (priv < csr_addr[9:8]);
    illegal   = !op_ok || ro_fail || priv_fail;
    do_write  = accept && !illegal && wr_intent;
  end

  // Result register: loads on acceptance, holds until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rd_out      <= '0;
      rd_we       <= 1'b0;
      rd_data     <= '0;
      exc_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      rd_out      <= rd;
      rd_we       <= !illegal && (rd != REG_W'(0));
      rd_data     <= illegal ? '0 : old_val;
      exc_illegal <= illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // CSR write port: one-cycle pulse after acceptance, independent of out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_we    <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
    end else begin
      csr_we <= do_write;
      if (do_write) begin
        csr_waddr <= ADDR_W'(csr_addr);
        csr_wdata <= new_val;
      end
    end
  end

endmodule

// File: doc/csr_exec_unit.md
CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, CSR and GPR data width; legal values 32 or 64.
REQ-002 SHALL provide parameter CHECK_PRIV, default 1, enabling the privilege check; 0 disables it.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  operation offered.
REQ-006 SHALL have port in_ready  out  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
REQ-008 SHALL have port csr_addr  in  12  target CSR address.
REQ-009 SHALL have port rs1_idx  in  5  rs1 index; doubles as uimm for immediate forms.
REQ-010 SHALL have port rs1_data  in  XLEN  rs1 value.
REQ-011 SHALL have port rd  in  5  destination GPR index.
REQ-012 SHALL have port priv  in  2  current privilege level (0 U, 1 S, 3 M).
REQ-013 SHALL have port csr_raddr  out  12  combinational read address, equal to csr_addr.
REQ-014 SHALL have port csr_rdata  in  XLEN  CSR file read data, same cycle.
REQ-015 SHALL have ports csr_we  out  1, csr_waddr  out  12, csr_wdata  out  XLEN; registered CSR write port.
REQ-016 SHALL have ports out_valid  out  1 and out_ready  in  1; result handshake.
REQ-017 SHALL have ports rd_out  out  5, rd_we  out  1, rd_data  out  XLEN, exc_illegal  out  1; registered result.

Function
REQ-018 in_ready SHALL equal !out_valid || out_ready.
REQ-019 On acceptance, the result register SHALL load, and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-020 out_valid SHALL stay 1 with rd_out/rd_we/rd_data/exc_illegal stable until out_valid && out_ready; it SHALL clear that cycle unless a new op is accepted.
REQ-021 Operand SHALL be rs1_data for op[2]==0, and zero-extended rs1_idx for op[2]==1.
REQ-022 Old value SHALL be csr_rdata, except when csr_we==1 and csr_waddr==csr_addr in the acceptance cycle; then it SHALL be csr_wdata (forwarding).
REQ-023 New value: RW/RWI = operand; RS/RSI = old | operand; RC/RCI = old & ~operand.
REQ-024 Write intent SHALL be 1 for RW/RWI, and SHALL be 1 for RS/RC/RSI/RCI only when rs1_idx != 0.
REQ-025 Illegal SHALL be asserted for op 000/100, or write intent with csr_addr[11:10]==2'b11, or (CHECK_PRIV==1 and priv < csr_addr[9:8]).
REQ-026 Legal op: rd_data = old value, rd_we = (rd != 0), rd_out = rd, exc_illegal = 0.
REQ-027 Illegal op: rd_we = 0, rd_data = 0, exc_illegal = 1, and no CSR write.
REQ-028 A legal op with write intent SHALL assert csr_we for exactly one cycle, in the cycle after acceptance, with csr_waddr = csr_addr and csr_wdata = new value; otherwise csr_we = 0.
REQ-029 csr_we SHALL be independent of out_ready; the write commits even while the result is stalled.
REQ-030 Back-to-back accepted ops SHALL each produce one result and at most one write, in order.

Reset
REQ-031 While rst is high, in_ready = 1 and out_valid, rd_we, exc_illegal, csr_we = 0. rd_out, rd_data, csr_waddr and csr_wdata SHALL be 0.
REQ-032 An op accepted in the cycle rst asserts SHALL be discarded, with no CSR write and no result.

Verification
REQ-033 CSRRW 0x340, rs1_data=0xDEADBEEF, rd=5, csr_rdata=0x11 -> next cycle: out_valid=1, rd_data=0x11, rd_we=1; csr_we=1, csr_wdata=0xDEADBEEF.
REQ-034 CSRRS 0x300, rs1_idx=0, rd=3, csr_rdata=0x88 -> rd_data=0x88, csr_we=0. Repeat with rs1_idx=2, rs1_data=0x8, csr_rdata=0x80 -> csr_wdata=0x88.
REQ-035 Back-to-back: CSRRWI 0x340 uimm=7, then CSRRCI 0x340 uimm=1 with stale csr_rdata=0 -> second rd_data=7, second csr_wdata=6.
REQ-036 CSRRW 0xC00 (read-only), and priv=0 access to 0x300 -> exc_illegal=1, rd_we=0, csr_we=0.
REQ-037 Hold out_ready=0 for 3 cycles after an op -> result stable, in_ready=0, exactly one csr_we pulse; release -> out_valid drops.
REQ-038 Assert rst mid-stall -> all outputs take their REQ-031 values immediately, with no further csr_we.
